// File: rtl/router_pkg.sv
// Shared definitions for the wormhole VC router.
// Flit type encodings and per-input-VC packet states.
package router_pkg;

   localparam logic [1:0] HEAD   = 2'b00;
   localparam logic [1:0] BODY   = 2'b01;
   localparam logic [1:0] TAIL   = 2'b10;
   localparam logic [1:0] SINGLE = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } ivc_state_t;

   function automatic logic is_head(input logic [1:0] ft);
      return (ft == HEAD) || (ft == SINGLE);
   endfunction

   function automatic logic is_last(input logic [1:0] ft);
      return (ft == TAIL) || (ft == SINGLE);
   endfunction

endpackage

// File: rtl/multi_vc_input_controller_rr_arbiter.sv
// Round-robin arbiter with a pointer that moves past the winner
// only when told to, so an unserved winner keeps its priority.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic          found;
   int            s;

   always_comb begin
      grant = '0;
      win   = ptr_q;
      found = 1'b0;
      idx   = '0;
      s     = 0;
      for (int k = 0; k < N; k++) begin
         s = int'(ptr_q) + k;
         if (s >= N) s = s - N;
         idx = PW'(s);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         if (win == PW'(N - 1)) ptr_d = '0;
         else                   ptr_d = win + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/multi_vc_input_controller.sv
// Per-port input controller: per-VC packet FSMs, downstream credit
// counters and round-robin selection of one VC for the crossbar.
module multi_vc_input_controller
   import router_pkg::*;
#(
   parameter int NUM_IVC   = 4,
   parameter int NUM_OVC   = 5,
   parameter int BUF_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_IVC-1:0]               fifo_empty,
   input  logic [NUM_IVC-1:0][1:0]          flit_type,
   input  logic [NUM_IVC-1:0][NUM_OVC-1:0]  candidate_out_vc,
   output logic [NUM_IVC-1:0][NUM_OVC-1:0]  req_vc,
   input  logic [NUM_IVC-1:0]               vc_granted,
   input  logic [NUM_IVC-1:0][NUM_OVC-1:0]  sel_out_vc,
   output logic                             sw_req,
   input  logic                             sw_grant,
   output logic                             flit_fire,
   output logic [NUM_IVC-1:0]               fire_ivc,
   output logic [NUM_OVC-1:0]               sel_xb_vc,
   input  logic [NUM_OVC-1:0]               credit_in,
   output logic                             credit_err
);

   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

   logic [NUM_IVC-1:0]              elig;
   logic [NUM_IVC-1:0]              gnt;
   logic [NUM_IVC-1:0]              perr;
   logic [NUM_IVC-1:0][NUM_OVC-1:0] ovc;
   logic [NUM_OVC-1:0][CW-1:0]      cred;
   logic [NUM_OVC-1:0]              cred_ok;
   logic [NUM_OVC-1:0]              ovf;
   logic [NUM_OVC-1:0]              xb_vc;
   logic                            err_q, err_d;

   for (genvar i = 0; i < NUM_IVC; i++) begin : g_ivc
      ivc_state_t         state_q, state_d;
      logic [NUM_OVC-1:0] ovc_q, ovc_d;
      logic [NUM_OVC-1:0] req_d;
      logic               perr_d;

      always_comb begin
         state_d = state_q;
         ovc_d   = ovc_q;
         req_d   = '0;
         perr_d  = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!fifo_empty[i]) begin
                  if (is_head(flit_type[i])) req_d  = candidate_out_vc[i];
                  else                       perr_d = 1'b1;
               end
               if (vc_granted[i]) begin
                  state_d = ACTIVE;
                  ovc_d   = sel_out_vc[i];
               end
            end
            ACTIVE: begin
               if (fire_ivc[i] && is_last(flit_type[i])) begin
                  state_d = IDLE;
                  ovc_d   = '0;
               end
            end
            default: ;
         endcase
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            state_q <= IDLE;
            ovc_q   <= '0;
         end else begin
            state_q <= state_d;
            ovc_q   <= ovc_d;
         end
      end

      assign req_vc[i] = req_d;
      assign perr[i]   = perr_d;
      assign ovc[i]    = ovc_q;
      // A VC is only worth arbitrating if its locked output has room
      assign elig[i]   = (state_q == ACTIVE) && !fifo_empty[i] &&
                         |(ovc_q & cred_ok);
   end

   rr_arbiter #(
      .N (NUM_IVC)
   ) u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     (elig),
      .advance (flit_fire),
      .grant   (gnt)
   );

   always_comb begin
      xb_vc = '0;
      for (int i = 0; i < NUM_IVC; i++) begin
         if (gnt[i]) xb_vc = xb_vc | ovc[i];
      end
   end

   assign sw_req    = |gnt;
   assign sel_xb_vc = xb_vc;
   assign flit_fire = sw_req & sw_grant;
   assign fire_ivc  = flit_fire ? gnt : '0;

   for (genvar j = 0; j < NUM_OVC; j++) begin : g_cred
      logic [CW-1:0] cnt_q, cnt_d;
      logic          dec, inc, ovf_d;

      assign dec = flit_fire & sel_xb_vc[j];
      assign inc = credit_in[j];

      always_comb begin
         cnt_d = cnt_q;
         ovf_d = 1'b0;
         if (inc && !dec) begin
            if (cnt_q == FULL) ovf_d = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
         end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) cnt_q <= FULL;
         else       cnt_q <= cnt_d;
      end

      assign cred[j]    = cnt_q;
      assign cred_ok[j] = (cnt_q != '0);
      assign ovf[j]     = ovf_d;
   end

   assign err_d = err_q | (|perr) | (|ovf);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign credit_err = err_q;

endmodule

// File: tb/tb_multi_vc_input_controller.sv
// Directed bench for multi_vc_input_controller with a small
// reactive model of the per-VC input buffers.
module tb_multi_vc_input_controller;

   localparam logic [1:0] HD = 2'b00;
   localparam logic [1:0] BD = 2'b01;
   localparam logic [1:0] TL = 2'b10;

   logic            clk = 1'b0;
   logic            rstn;
   logic [3:0]      fifo_empty;
   logic [3:0][1:0] flit_type;
   logic [3:0][4:0] cand;
   logic [3:0][4:0] req_vc;
   logic [3:0]      vc_granted;
   logic [3:0][4:0] sel_out_vc;
   logic            sw_req;
   logic            sw_grant;
   logic            flit_fire;
   logic [3:0]      fire_ivc;
   logic [4:0]      sel_xb_vc;
   logic [4:0]      credit_in;
   logic            credit_err;

   logic [1:0] fl [4][8];
   int         rd [4];
   int         wr [4];
   int         n_chk = 0;
   int         n_fail = 0;
   logic [3:0] rr_exp [5];

   always #5 clk = ~clk;

   multi_vc_input_controller #(
      .NUM_IVC   (4),
      .NUM_OVC   (5),
      .BUF_DEPTH (4)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .fifo_empty       (fifo_empty),
      .flit_type        (flit_type),
      .candidate_out_vc (cand),
      .req_vc           (req_vc),
      .vc_granted       (vc_granted),
      .sel_out_vc       (sel_out_vc),
      .sw_req           (sw_req),
      .sw_grant         (sw_grant),
      .flit_fire        (flit_fire),
      .fire_ivc         (fire_ivc),
      .sel_xb_vc        (sel_xb_vc),
      .credit_in        (credit_in),
      .credit_err       (credit_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void drive_fifo();
      for (int i = 0; i < 4; i++) begin
         fifo_empty[i] = (rd[i] == wr[i]);
         flit_type[i]  = (rd[i] == wr[i]) ? HD : fl[i][rd[i]];
      end
   endfunction

   function automatic void push(input int i, input logic [1:0] t);
      fl[i][wr[i]] = t;
      wr[i]++;
   endfunction

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic tick();
      logic [3:0] f;
      f = fire_ivc;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (f[i] && rd[i] < wr[i]) rd[i]++;
      end
      vc_granted = '0;
      sel_out_vc = '0;
      credit_in  = '0;
      drive_fifo();
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 4; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
      cand       = '0;
      vc_granted = '0;
      sel_out_vc = '0;
      sw_grant   = 1'b0;
      credit_in  = '0;
      drive_fifo();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      rr_exp[0] = 4'b0001;
      rr_exp[1] = 4'b0010;
      rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000;
      rr_exp[4] = 4'b0001;

      // reset state
      rstn = 1'b0;
      clear_inputs();
      mid();
      chk("rst_req_vc", req_vc, 0);
      chk("rst_sw_req", sw_req, 0);
      chk("rst_fire", flit_fire, 0);
      chk("rst_fire_ivc", fire_ivc, 0);
      chk("rst_sel_xb", sel_xb_vc, 0);
      chk("rst_err", credit_err, 0);
      chk("rst_cred0", dut.cred[0], 4);
      chk("rst_cred4", dut.cred[4], 4);
      do_reset();

      // single packet on IVC0
      push(0, HD); push(0, BD); push(0, TL);
      cand[0]  = 5'b00100;
      sw_grant = 1'b1;
      drive_fifo();
      mid();
      chk("p1_req", req_vc, 32'h0000_0004);
      tick();
      mid();
      chk("p1_noreq_c1", sw_req, 0);
      tick();
      vc_granted    = 4'b0001;
      sel_out_vc[0] = 5'b00100;
      mid();
      chk("p1_nobypass", sw_req, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("p1_swreq", sw_req, 1);
         chk("p1_xb", sel_xb_vc, 5'b00100);
         chk("p1_fire_ivc", fire_ivc, 4'b0001);
         chk("p1_req_active", req_vc, 0);
         tick();
      end
      push(0, HD);
      drive_fifo();
      mid();
      chk("p1_idle_req", req_vc, 32'h0000_0004);
      chk("p1_idle_sw", sw_req, 0);
      chk("p1_cred2", dut.cred[2], 1);

      // credit stall on output VC1
      do_reset();
      push(1, HD);
      for (int k = 0; k < 4; k++) push(1, BD);
      push(1, TL);
      cand[1]       = 5'b00010;
      sw_grant      = 1'b1;
      vc_granted    = 4'b0010;
      sel_out_vc[1] = 5'b00010;
      drive_fifo();
      mid();
      tick();
      for (int k = 0; k < 4; k++) begin
         mid();
         chk("cs_fire", fire_ivc, 4'b0010);
         tick();
      end
      mid();
      chk("cs_stall", sw_req, 0);
      chk("cs_cred0", dut.cred[1], 0);
      tick();
      credit_in = 5'b00010;
      mid();
      chk("cs_stall_cin", sw_req, 0);
      tick();
      mid();
      chk("cs_resume", fire_ivc, 4'b0010);
      tick();
      mid();
      chk("cs_stall2", sw_req, 0);

      // round-robin fairness
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(i, HD); push(i, BD); push(i, BD); push(i, BD);
         cand[i]       = 5'(1 << i);
         sel_out_vc[i] = 5'(1 << i);
      end
      vc_granted = 4'b1111;
      drive_fifo();
      mid();
      tick();
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("rr_hold_req", sw_req, 1);
         chk("rr_hold_xb", sel_xb_vc, 5'b00001);
         chk("rr_hold_fire", fire_ivc, 0);
         tick();
      end
      sw_grant = 1'b1;
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("rr_seq", fire_ivc, rr_exp[k]);
         tick();
      end

      // fire and credit return on the same VC, then overflow
      do_reset();
      push(0, HD); push(0, BD); push(0, TL);
      cand[0]       = 5'b00100;
      sel_out_vc[0] = 5'b00100;
      vc_granted    = 4'b0001;
      sw_grant      = 1'b1;
      drive_fifo();
      mid();
      tick();
      credit_in = 5'b00100;
      mid();
      chk("sim_fire", fire_ivc, 4'b0001);
      tick();
      mid();
      chk("sim_cred", dut.cred[2], 4);
      chk("sim_noerr", credit_err, 0);
      sw_grant  = 1'b0;
      credit_in = 5'b00100;
      mid();
      tick();
      mid();
      chk("ovf_err", credit_err, 1);
      chk("ovf_cred", dut.cred[2], 4);

      // protocol error, then reset mid-packet
      do_reset();
      mid();
      chk("pe_err_clr", credit_err, 0);
      push(3, BD);
      cand[3] = 5'b01000;
      drive_fifo();
      mid();
      chk("pe_req0", req_vc, 0);
      tick();
      mid();
      chk("pe_err", credit_err, 1);
      tick();
      clear_inputs();
      push(0, HD); push(0, BD); push(0, TL);
      cand[0]       = 5'b00100;
      sel_out_vc[0] = 5'b00100;
      vc_granted    = 4'b0001;
      sw_grant      = 1'b1;
      drive_fifo();
      mid();
      tick();
      mid();
      chk("mr_fire", fire_ivc, 4'b0001);
      tick();
      #2;
      rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
      drive_fifo();
      #1;
      chk("mr_sw_req", sw_req, 0);
      chk("mr_fire0", flit_fire, 0);
      chk("mr_fire_ivc", fire_ivc, 0);
      chk("mr_xb", sel_xb_vc, 0);
      chk("mr_req_vc", req_vc, 0);
      chk("mr_err", credit_err, 0);
      chk("mr_cred2", dut.cred[2], 4);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      mid();
      chk("post_cred2", dut.cred[2], 4);
      chk("post_sw_req", sw_req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
